// File: rtl/demux8_2_stream.sv
// demux8_2_stream: routes one valid/ready byte stream into two buffered outputs with per-channel counters
module demux8_2_stream_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic             full,
  output logic             valid,
  output logic [WIDTH-1:0] rdata
);
  localparam int AW = $clog2(DEPTH);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0] wp, rp;
  logic [AW:0] cnt;
  assign full = cnt == (AW+1)'(DEPTH);
  assign valid = cnt != '0;
  assign rdata = mem[rp];
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wp <= '0;
      rp <= '0;
      cnt <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (push) begin
        mem[wp] <= wdata;
        wp <= wp + 1'b1;
      end
      if (pop) rp <= rp + 1'b1;
      cnt <= cnt + (AW+1)'(push) - (AW+1)'(pop);
    end
  end
endmodule

module demux8_2_stream #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 2,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_sel,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] a_data,
  output logic             a_valid,
  input  logic             a_ready,
  output logic [WIDTH-1:0] b_data,
  output logic             b_valid,
  input  logic             b_ready,
  output logic [CNT_W-1:0] a_count,
  output logic [CNT_W-1:0] b_count
);
  logic full_a, full_b, push_a, push_b;
  // ready reflects only pre-edge fullness, so a simultaneous pop never lets a byte through a full FIFO
  assign in_ready = in_sel ? !full_a : !full_b;
  assign push_a = in_valid && in_sel && !full_a;
  assign push_b = in_valid && !in_sel && !full_b;
  demux8_2_stream_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_a (
    .clk(clk), .rst_n(rst_n), .push(push_a), .wdata(in_data),
    .pop(a_valid && a_ready), .full(full_a), .valid(a_valid), .rdata(a_data)
  );
  demux8_2_stream_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_b (
    .clk(clk), .rst_n(rst_n), .push(push_b), .wdata(in_data),
    .pop(b_valid && b_ready), .full(full_b), .valid(b_valid), .rdata(b_data)
  );
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_count <= '0;
      b_count <= '0;
    end else begin
      if (push_a) a_count <= a_count + 1'b1;
      if (push_b) b_count <= b_count + 1'b1;
    end
  end
endmodule
